// File: rtl/radix9_serial_subtractor.sv
// Digit-serial radix-9 subtractor: one digit per clock, LSD first, with a
// single-cycle done pulse. Operands are packed 4-bit digits that must lie in 0..8.
module radix9_serial_subtractor #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bin,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] diff,
    output logic              bout,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is sampled only in IDLE; done pulses for exactly one
    // cycle when diff/bout/err become valid, and those hold until the next start.
    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    shadow;
    logic [IW-1:0]   idx;
    logic            borrow;

    logic            in_bad;
    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [5:0]      t;
    logic            t_neg;
    logic [3:0]      res_dig;
    logic [W-1:0]    shadow_nx;
    logic            last_dig;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd8) bad = 1'b1;
        end
        return bad;
    endfunction

    // t ranges over -9..8; bit 5 is the sign, and adding 9 to the low nibble
    // of a negative t yields the correct 0..8 digit modulo 16.
    always_comb begin
        in_bad    = has_bad_digit(a) || has_bad_digit(b);
        a_dig     = a_q[4*idx +: 4];
        b_dig     = b_q[4*idx +: 4];
        t         = {2'b00, a_dig} - {2'b00, b_dig} - {5'd0, borrow};
        t_neg     = t[5];
        res_dig   = t_neg ? (t[3:0] + 4'd9) : t[3:0];
        shadow_nx = shadow;
        shadow_nx[4*idx +: 4] = res_dig;
        last_dig  = (idx == IW'(NDIG - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            err    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            shadow <= '0;
            idx    <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        idx    <= '0;
                        shadow <= '0;
                        busy   <= 1'b1;
                        if (in_bad) begin
                            diff  <= '0;
                            bout  <= 1'b0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    shadow <= shadow_nx;
                    borrow <= t_neg;
                    if (last_dig) begin
                        diff  <= shadow_nx;
                        bout  <= t_neg;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix9_serial_subtractor.sv
// Bench for radix9_serial_subtractor: directed cases with literal results plus
// randomized traffic checked every cycle against an integer-arithmetic model.
module tb_radix9_serial_subtractor;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         bin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         err;

    int total_checks  = 0;
    int passed_checks = 0;

    radix9_serial_subtractor #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .err   (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int to_int(input logic [W-1:0] v);
        int acc = 0;
        int wt  = 1;
        for (int i = 0; i < NDIG; i++) begin
            acc += int'(v[4*i +: 4]) * wt;
            wt  *= 9;
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] to_r9(input int x);
        logic [W-1:0] v = '0;
        int r = x;
        for (int i = 0; i < NDIG; i++) begin
            v[4*i +: 4] = 4'(r % 9);
            r = r / 9;
        end
        return v;
    endfunction

    function automatic int pow9n();
        int m = 1;
        for (int i = 0; i < NDIG; i++) m *= 9;
        return m;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd8) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int d = to_int(x) - to_int(y) - int'(bi);
        if (d < 0) d += pow9n();
        return to_r9(d);
    endfunction

    function automatic logic model_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        return (to_int(x) < to_int(y) + int'(bi));
    endfunction

    // Expected outputs, advanced from the bench's own stimulus.
    logic         m_busy, m_done, m_bout, m_err, p_bout;
    logic [W-1:0] m_diff, p_diff;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_err  <= 1'b0;
            m_left <= 0;
            p_diff <= '0;
            p_bout <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_diff <= p_diff;
                m_bout <= p_bout;
                m_done <= 1'b1;
            end
            m_left <= m_left - 1;
        end else if (start) begin
            m_busy <= 1'b1;
            if (has_bad(a) || has_bad(b)) begin
                m_diff <= '0;
                m_bout <= 1'b0;
                m_err  <= 1'b1;
                m_done <= 1'b1;
            end else begin
                m_err  <= 1'b0;
                m_left <= NDIG;
                p_diff <= model_diff(a, b, bin);
                p_bout <= model_bout(a, b, bin);
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("mon_busy", 32'(busy), 32'(m_busy));
        check("mon_done", 32'(done), 32'(m_done));
        check("mon_diff", 32'(diff), 32'(m_diff));
        check("mon_bout", 32'(bout), 32'(m_bout));
        check("mon_err",  32'(err),  32'(m_err));
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input string name, input int exp_lat, input bit intrude);
        int n = 0;
        while (!done && n < 20) begin
            if (intrude && n == 1) begin
                start = 1'b1;
                a     = 16'h0000;
                b     = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic bi, input int exp_lat, input bit intrude);
        @(negedge clk);
        a     = x;
        b     = y;
        bin   = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_e0"}, 32'(busy), 32'd1);
        a   = 16'($urandom);
        b   = 16'($urandom);
        bin = 1'($urandom_range(0, 1));
        wait_done(name, exp_lat, intrude);
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v = '0;
        int pos;
        for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 8));
        if ($urandom_range(0, 15) == 0) begin
            pos = int'($urandom_range(0, NDIG - 1));
            v[4*pos +: 4] = 4'($urandom_range(9, 15));
        end
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_err",  32'(err),  32'd0);
        rst_n = 1'b1;

        run_op("basic", 16'h8888, 16'h1234, 1'b0, NDIG, 1'b0);
        check("basic_diff", 32'(diff), 32'h7654);
        check("basic_bout", 32'(bout), 32'd0);
        check("basic_err",  32'(err),  32'd0);

        run_op("wrap", 16'h0000, 16'h0001, 1'b0, NDIG, 1'b0);
        check("wrap_diff", 32'(diff), 32'h8888);
        check("wrap_bout", 32'(bout), 32'd1);

        run_op("xdigit", 16'h0010, 16'h0001, 1'b0, NDIG, 1'b0);
        check("xdigit_diff", 32'(diff), 32'h0008);
        check("xdigit_bout", 32'(bout), 32'd0);

        run_op("bin1", 16'h3333, 16'h3333, 1'b1, NDIG, 1'b0);
        check("bin1_diff", 32'(diff), 32'h8888);
        check("bin1_bout", 32'(bout), 32'd1);

        run_op("baddig", 16'h0009, 16'h0000, 1'b0, 0, 1'b0);
        check("baddig_err",  32'(err),  32'd1);
        check("baddig_diff", 32'(diff), 32'h0000);
        check("baddig_bout", 32'(bout), 32'd0);

        run_op("intrude", 16'h8888, 16'h1234, 1'b0, NDIG, 1'b1);
        check("intrude_diff", 32'(diff), 32'h7654);
        check("intrude_bout", 32'(bout), 32'd0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a     = 16'h1111;
        b     = 16'h0000;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        start = 1'b1;
        a     = 16'h0005;
        b     = 16'h0001;
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        a     = 16'h2222;
        b     = 16'h1111;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("rel_busy_e0", 32'(busy), 32'd1);
        wait_done("rel", NDIG, 1'b0);
        check("rel_diff", 32'(diff), 32'h1111);

        // Random traffic, start toggling freely including during RUN/DONE.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = rand_op();
            b     = ($urandom_range(0, 7) == 0) ? a : rand_op();
            bin   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (NDIG + 4) @(negedge clk);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/radix9_serial_subtractor.md
RADIX9_SERIAL_SUBTRACTOR -- requirements
Module: radix9_serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: NDIG, default 4, the number of radix-9 digits per operand, with NDIG >= 1.
REQ-002 The block SHALL provide port clk, input, width 1: the single clock, rising-edge active.
REQ-003 The block SHALL provide port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-004 The block SHALL provide port start, input, width 1: operation request, sampled on rising clk edges.
REQ-005 The block SHALL provide port bin, input, width 1: borrow-in, sampled together with start.
REQ-006 The block SHALL provide port a, input, width 4*NDIG: minuend, packed radix-9 digits, digit i at bits [4i+3:4i], with the LSD at [3:0].
REQ-007 The block SHALL provide port b, input, width 4*NDIG: subtrahend, packed the same way as a.
REQ-008 The block SHALL provide port busy, output, width 1: high whenever the block is not in IDLE.
REQ-009 The block SHALL provide port done, output, width 1: single-cycle completion pulse.
REQ-010 The block SHALL provide port diff, output, width 4*NDIG: result digits, packed the same way as a.
REQ-011 The block SHALL provide port bout, output, width 1: final borrow-out.
REQ-012 The block SHALL provide port err, output, width 1: set when the last accepted operation had an invalid digit.

Function
REQ-013 The block SHALL implement an FSM with the states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-014 In IDLE, a rising edge with start=1 SHALL latch a, b and bin and SHALL clear the digit index to 0.
REQ-015 On that same edge, if any digit of a or b is >8, the block SHALL go to DONE with diff=0, bout=0 and err=1, and SHALL skip RUN.
REQ-016 Otherwise, on that edge the block SHALL set err=0 and go to RUN.
REQ-017 Each RUN edge SHALL process exactly one digit i, LSD first: t = a_i - b_i - borrow, with borrow initialised to the latched bin.
REQ-018 If t<0, the digit result SHALL be t+9 and the next borrow SHALL be 1; otherwise the digit result SHALL be t and the next borrow SHALL be 0.
REQ-019 Digit results SHALL accumulate in an internal shadow register; the diff port SHALL NOT change during RUN.
REQ-020 On the edge that processes digit NDIG-1, the block SHALL copy the shadow register to diff, set bout to the final borrow, and go to DONE.
REQ-021 Each result digit SHALL lie in 0..8, so diff SHALL equal (A - B - bin) mod 9^NDIG and bout SHALL equal 1 iff A < B + bin.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return unconditionally to IDLE.
REQ-023 Latency: done SHALL be high in the cycle following the NDIG-th rising edge after the start edge, or following the start edge itself in the error case.
REQ-024 start SHALL be ignored in RUN and DONE, with no queuing; an operation can start no earlier than the first edge after leaving DONE.
REQ-025 diff, bout and err SHALL hold their values from DONE until the next accepted start.
REQ-026 Changes on a, b or bin after the start edge SHALL NOT affect the result.

Reset
REQ-027 While rst_n=0, asynchronously and regardless of clk, the block SHALL force state=IDLE, busy=0, done=0, diff=0, bout=0, err=0, shadow=0, index=0 and borrow=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-029 start SHALL be ignored while rst_n=0; the first edge with rst_n=1 and start=1 SHALL be accepted.

Verification
REQ-030 The bench SHALL cover: NDIG=4, a=16'h8888, b=16'h1234, bin=0, start at edge E0 -> busy=1 from E0, done=1 only after E4, diff=16'h7654, bout=0, err=0.
REQ-031 The bench SHALL cover: a=16'h0000, b=16'h0001, bin=0 -> diff=16'h8888, bout=1 (wrap-around).
REQ-032 The bench SHALL cover: a=16'h0010, b=16'h0001, bin=0 -> diff=16'h0008, bout=0 (borrow across a digit); and a=b=16'h3333, bin=1 -> diff=16'h8888, bout=1.
REQ-033 The bench SHALL cover: a=16'h0009, b=16'h0000 -> done=1 immediately after the start edge, err=1, diff=16'h0000, bout=0, with RUN never entered.
REQ-034 The bench SHALL cover: start re-asserted with different operands during RUN -> ignored, and the first result is unchanged.
REQ-035 The bench SHALL cover: rst_n driven low after E2 of an operation -> busy=0, diff=0 immediately with no clock edge, and no done pulse.
